// File: rtl/sram_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_ctrl_if
// Pipeline-side bundle between the EX/MEM stage registers and sram_ctrl.
//   mem_r_en   : load request
//   mem_w_en   : store request (wins when both requests are high)
//   alu_res    : byte address of the access
//   st_val     : store data
//   ready      : access complete or nothing pending; freeze = ~ready
//   read_data  : load result
// master = pipeline side, slave = controller side.
// -----------------------------------------------------------------------------
interface sram_ctrl_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic        ready;
    logic [31:0] read_data;

    modport master (
        output mem_r_en,
        output mem_w_en,
        output alu_res,
        output st_val,
        input  ready,
        input  read_data
    );

    modport slave (
        input  mem_r_en,
        input  mem_w_en,
        input  alu_res,
        input  st_val,
        output ready,
        output read_data
    );
endinterface

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// MEM-stage data-memory controller. Each 32-bit load/store is split into two
// 16-bit accesses (low half, then high half) on an external asynchronous SRAM.
// While an access is in flight, ready is low so the pipeline stays frozen.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : pipeline-side request/response bundle (sram_ctrl_if.slave)
//   sram_addr  : SRAM halfword address
//   sram_dq    : SRAM bidirectional data bus
//   sram_we_n  : SRAM write enable (active low)
//   sram_oe_n  : SRAM output enable (active low)
//   sram_ce_n  : SRAM chip enable (active low)
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ACCESS_CYCLES = 2,
    parameter int DMEM_BASE     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    sram_ctrl_if.slave  bus,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int               CNT_W    = $clog2(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    // Only 19 address bits feed the 17-bit word index, so the base offset
    // can be subtracted in 19-bit arithmetic without losing anything.
    localparam logic [18:0]      BASE_LO  = 19'(DMEM_BASE);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             is_write_reg, is_write_next;
    logic [31:0]      read_data_reg, read_data_next;

    logic             req;
    logic             in_access;
    logic             phase_last;
    logic             dq_drive;
    logic [15:0]      dq_out;
    logic [18:0]      offset;
    logic [16:0]      word;
    logic             unused_addr_bits;

    assign req        = bus.mem_r_en | bus.mem_w_en;
    assign in_access  = (state_reg == ST_LO) || (state_reg == ST_HI);
    assign phase_last = (cnt_reg == CNT_LAST);

    assign offset = bus.alu_res[18:0] - BASE_LO;
    assign word   = offset[18:2];
    // Byte-lane bits and the address bits above the SRAM window are ignored.
    assign unused_addr_bits = ^{bus.alu_res[31:19], offset[1:0]};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        is_write_next  = is_write_reg;
        read_data_next = read_data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next    = ST_LO;
                    cnt_next      = '0;
                    // A simultaneous load and store is treated as a store.
                    is_write_next = bus.mem_w_en;
                end
            end
            ST_LO: begin
                if (phase_last) begin
                    if (!is_write_reg) begin
                        read_data_next[15:0] = sram_dq;
                    end
                    state_next = ST_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_HI: begin
                if (phase_last) begin
                    if (!is_write_reg) begin
                        read_data_next[31:16] = sram_dq;
                    end
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                // DONE: the pipeline advances this cycle; the next request is
                // only considered from IDLE.
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            is_write_reg  <= 1'b0;
            read_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            is_write_reg  <= is_write_next;
            read_data_reg <= read_data_next;
        end
    end

    // -------------------------------------------------------------------------
    // SRAM strobes: decoded purely from registered state so they are glitch
    // free and drop together with an asynchronous reset.
    // -------------------------------------------------------------------------
    assign sram_ce_n = ~in_access;
    assign sram_oe_n = ~(in_access & ~is_write_reg);
    // WE is released on the last cycle of each phase so data is held past
    // the rising edge of WE.
    assign sram_we_n = ~(in_access & is_write_reg & (cnt_reg < CNT_LAST));

    always_comb begin
        sram_addr = '0;
        if (state_reg == ST_LO) begin
            sram_addr = {word, 1'b0};
        end else if (state_reg == ST_HI) begin
            sram_addr = {word, 1'b1};
        end
    end

    assign dq_drive = in_access & is_write_reg;
    assign dq_out   = (state_reg == ST_HI) ? bus.st_val[31:16] : bus.st_val[15:0];
    assign sram_dq  = dq_drive ? dq_out : 16'bz;

    // -------------------------------------------------------------------------
    // Pipeline side
    // -------------------------------------------------------------------------
    assign bus.ready     = (state_reg == ST_IDLE) ? ~req : (state_reg == ST_DONE);
    assign bus.read_data = read_data_reg;

endmodule
